uart_reg_responder: RTL and testbench

Byte-level command responder on the receive/transmit pair of the UART: consumes bytes from the receiver's `m_valid`/`m_data` strobe, decodes read/write commands against a 16-entry 8-bit register space, and returns one response byte per command to the transmitter over `s_valid`/`s_ready`. It is the device end of a host-initiated register-access protocol and sits between the `uart` top and the fabric logic that consumes the control registers.

---
 rtl/uart_reg_responder_if.sv | 31 +++
 rtl/uart_reg_responder.sv | 133 +++++++++++++
 tb/tb_uart_reg_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_responder_if.sv
// Byte stream in from the UART receiver, response byte out to the transmitter, register file out.
// Pure wiring bundle: no storage, no latency.
// Backpressure lives on the response side only (s_valid/s_ready); the receive strobe cannot be stalled.
interface uart_reg_responder_if;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic [111:0] regs;

    // Host side: owns the receive strobe and the transmitter ready.
    modport master (
        output m_valid,
        output m_data,
        output s_ready,
        input  s_valid,
        input  s_data,
        input  regs
    );

    // Responder side.
    modport slave (
        input  m_valid,
        input  m_data,
        input  s_ready,
        output s_valid,
        output s_data,
        output regs
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Register-access responder: decodes read/write command bytes against 16 x 8-bit registers, returns one byte per command.
// Latency: response valid one cycle after the deciding byte (command for reads/NAKs, data byte for writes).
// Backpressure: response held until s_ready; bytes arriving meanwhile are dropped and counted as overruns.
module uart_reg_responder #(
    parameter int unsigned TIMEOUT_CLKS = 104160,
    parameter logic [7:0]  DEVICE_ID    = 8'hA7
) (
    input  logic                 clk,
    input  logic                 rstn,
    uart_reg_responder_if.slave  bus
);
    localparam int unsigned   TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    ACK        = 8'h06;
    localparam logic [7:0]    NAK        = 8'h15;
    localparam logic [3:0]    ADDR_OVR   = 4'hE;
    localparam logic [3:0]    ADDR_ID    = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       addr_q,  addr_d;
    logic [7:0]       resp_q,  resp_d;
    logic [7:0]       ovr_q,   ovr_d;
    logic [13:0][7:0] regs_q,  regs_d;

    logic [7:0]       rd_val;
    logic             cmd_bad;
    logic             cmd_wr;
    logic [3:0]       cmd_addr;

    assign cmd_bad  = (bus.m_data[6:4] != 3'b000);
    assign cmd_wr   = bus.m_data[7];
    assign cmd_addr = bus.m_data[3:0];

    // Read mux: sampled in the decode cycle, so 0xE shows the count before any overrun this cycle.
    always_comb begin
        rd_val = 8'h00;
        case (cmd_addr)
            ADDR_OVR: rd_val = ovr_q;
            ADDR_ID:  rd_val = DEVICE_ID;
            default:  rd_val = regs_q[cmd_addr];
        endcase
    end

    // Command FSM: decode, collect write data with timeout, hold response until accepted.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        addr_d  = addr_q;
        resp_d  = resp_q;
        ovr_d   = ovr_q;
        regs_d  = regs_q;

        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    if (cmd_bad) begin
                        resp_d  = NAK;
                        state_d = RESPOND;
                    end else if (!cmd_wr) begin
                        resp_d  = rd_val;
                        state_d = RESPOND;
                    end else if (cmd_addr >= ADDR_OVR) begin
                        // Read-only targets are refused at once; no data byte is awaited.
                        resp_d  = NAK;
                        state_d = RESPOND;
                    end else begin
                        addr_d  = cmd_addr;
                        timer_d = '0;
                        state_d = GET_DATA;
                    end
                end
            end

            GET_DATA: begin
                // A data byte arriving in the expiry cycle still completes the write.
                if (bus.m_valid) begin
                    regs_d[addr_q] = bus.m_data;
                    resp_d         = ACK;
                    state_d        = RESPOND;
                end else if (timer_q == TIMER_LAST) begin
                    resp_d  = NAK;
                    state_d = RESPOND;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            RESPOND: begin
                if (bus.m_valid && (ovr_q != 8'hFF)) begin
                    ovr_d = ovr_q + 8'd1;
                end
                if (bus.s_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any pending response or partial write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            timer_q <= '0;
            addr_q  <= 4'h0;
            resp_q  <= 8'h00;
            ovr_q   <= 8'h00;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
            ovr_q   <= ovr_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.s_valid = (state_q == RESPOND);
    assign bus.s_data  = resp_q;
    assign bus.regs    = regs_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed plus randomized bench for uart_reg_responder against a byte-level protocol model.
// Latency: checks response one cycle after the deciding byte.
// Backpressure: exercises held responses with overrun strobes.
module tb_uart_reg_responder;
    localparam int unsigned T   = 20;
    localparam logic [7:0]  ID  = 8'hA7;
    localparam logic [7:0]  ACK = 8'h06;
    localparam logic [7:0]  NAK = 8'h15;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    uart_reg_responder_if bus ();

    uart_reg_responder #(
        .TIMEOUT_CLKS(T),
        .DEVICE_ID   (ID)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Protocol model: register contents and overrun count.
    logic [7:0] mregs [14];
    int         movr;

    task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 14; i++) mregs[i] = 8'h00;
        movr = 0;
    endtask

    function automatic logic [111:0] mdl_regs();
        logic [111:0] v;
        for (int i = 0; i < 14; i++) v[8*i +: 8] = mregs[i];
        return v;
    endfunction

    function automatic logic [7:0] mdl_read(input logic [3:0] a);
        if (a == 4'hF) return ID;
        if (a == 4'hE) return 8'(movr);
        return mregs[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.m_valid = 1'b1;
        bus.m_data  = b;
        step();
        bus.m_valid = 1'b0;
        bus.m_data  = 8'($urandom);
    endtask

    // Hold the response for 'hold' cycles with 'nstr' stray strobes, then accept it.
    task automatic take_resp(input string tag, input logic [7:0] exp, input int hold, input int nstr);
        check({tag, "_vld"}, bus.s_valid, 1'b1);
        check({tag, "_dat"}, bus.s_data, exp);
        bus.s_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.m_valid = (h < nstr);
            bus.m_data  = 8'($urandom);
            step();
            if (h < nstr && movr < 255) movr++;
            check({tag, "_held_vld"}, bus.s_valid, 1'b1);
            check({tag, "_held_dat"}, bus.s_data, exp);
        end
        bus.m_valid = 1'b0;
        bus.s_ready = 1'b1;
        step();
        bus.s_ready = 1'b0;
        check({tag, "_done"}, bus.s_valid, 1'b0);
    endtask

    // One full command exchange, expected response derived from the protocol rules.
    task automatic do_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                          input int gap, input int hold, input int nstr);
        logic [7:0] exp;
        send_byte(cmd);
        if (cmd[6:4] != 3'b000) begin
            exp = NAK;
        end else if (!cmd[7]) begin
            exp = mdl_read(cmd[3:0]);
        end else if (cmd[3:0] >= 4'hE) begin
            exp = NAK;
        end else begin
            check({tag, "_wait"}, bus.s_valid, 1'b0);
            repeat (gap) step();
            send_byte(dat);
            mregs[cmd[3:0]] = dat;
            exp = ACK;
        end
        check({tag, "_regs"}, bus.regs, mdl_regs());
        take_resp(tag, exp, hold, nstr);
    endtask

    initial begin
        int cnt;
        logic [7:0] cmd;
        bus.m_valid = 1'b0;
        bus.m_data  = 8'h00;
        bus.s_ready = 1'b0;
        mdl_reset();

        // Reset values
        step();
        step();
        check("rst_svalid", bus.s_valid, 1'b0);
        check("rst_sdata", bus.s_data, 8'h00);
        check("rst_regs", bus.regs, '0);
        rstn = 1'b1;
        step();

        // Reads of ID and a cleared register
        do_cmd("rd_id", 8'h0F, 8'h00, 0, 0, 0);
        do_cmd("rd_r3", 8'h03, 8'h00, 0, 0, 0);

        // Write then read back
        do_cmd("wr_r5", 8'h85, 8'h3C, 0, 0, 0);
        check("r5_bits", bus.regs[47:40], 8'h3C);
        do_cmd("rd_r5", 8'h05, 8'h00, 0, 0, 0);

        // Invalid command and write to a read-only address
        do_cmd("bad_cmd", 8'h90, 8'h00, 0, 0, 0);
        do_cmd("wr_id", 8'h8F, 8'h00, 0, 0, 0);

        // Timeout: NAK exactly T cycles after entering GET_DATA
        send_byte(8'h82);
        cnt = 0;
        while (bus.s_valid !== 1'b1 && cnt < T + 5) begin
            step();
            cnt++;
        end
        check("tmo_cycles", cnt, T);
        check("tmo_r2", bus.regs[23:16], mregs[2]);
        take_resp("tmo", NAK, 0, 0);

        // Data byte in the expiry cycle wins
        send_byte(8'h82);
        repeat (T - 1) step();
        check("exp_pending", bus.s_valid, 1'b0);
        send_byte(8'h5A);
        mregs[2] = 8'h5A;
        check("exp_r2", bus.regs[23:16], 8'h5A);
        take_resp("exp", ACK, 0, 0);

        // Overruns while the transmitter stalls
        do_cmd("hold_rd", 8'h05, 8'h00, 0, 4, 3);
        do_cmd("rd_ovr3", 8'h0E, 8'h00, 0, 0, 0);
        do_cmd("ovr_flood", 8'h01, 8'h00, 0, 300, 300);
        do_cmd("rd_ovr_sat", 8'h0E, 8'h00, 0, 0, 0);

        // Reset while waiting for write data
        send_byte(8'h84);
        rstn = 1'b0;
        #1;
        mdl_reset();
        check("rst_gd_svalid", bus.s_valid, 1'b0);
        check("rst_gd_regs", bus.regs, '0);
        step();
        rstn = 1'b1;
        step();
        do_cmd("fresh_after_gd", 8'h0F, 8'h00, 0, 0, 0);

        // Reset while a response is pending
        send_byte(8'h0F);
        check("pend_svalid", bus.s_valid, 1'b1);
        rstn = 1'b0;
        #1;
        mdl_reset();
        check("rst_rsp_svalid", bus.s_valid, 1'b0);
        check("rst_rsp_sdata", bus.s_data, 8'h00);
        step();
        rstn = 1'b1;
        step();
        do_cmd("fresh_after_rsp", 8'h0E, 8'h00, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) cmd = 8'($urandom);
            else cmd = {1'($urandom), 3'b000, 4'($urandom)};
            do_cmd("rand", cmd, 8'($urandom), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end
        do_cmd("rand_ovr", 8'h0E, 8'h00, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
